adc_serial_resp: RTL and testbench



---
 rtl/adc_resp_pkg.sv | 16 +
 rtl/adc_serial_resp_sync_edge.sv | 25 ++
 rtl/adc_serial_resp.sv | 106 ++++++++++
 tb/tb_adc_serial_resp.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: shared state type, line levels and default width for adc_serial_resp (state TAIL exists only with ADC_RESP_LSB_TAIL_EN)
package adc_resp_pkg;
   localparam int   ADC_DATA_W     = 8;
   localparam logic ADC_IDLE_LEVEL = 1'b1;
   localparam logic ADC_NULL_LEVEL = 1'b0;
   typedef enum logic [2:0] {
      IDLE,
      MUX,
      NULLB,
      DATA,
`ifdef ADC_RESP_LSB_TAIL_EN
      TAIL,
`endif
      DONE
   } adc_resp_state_t;
endpackage

// File: rtl/adc_serial_resp_sync_edge.sv
// sync_edge: STAGES-deep synchronizer plus one edge-detect flop; rise/fall are decoded from the last two flops only
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic              prev;
   // shift the pin through the synchronizer and keep one delayed copy of its output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= '1;
         prev <= 1'b1;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
      end
   end
   assign rise = ~prev & sync[STAGES-1];
   assign fall = prev & ~sync[STAGES-1];
endmodule

// File: rtl/adc_serial_resp.sv
// adc_serial_resp: ADC0831-style serial responder (null bit, MSB-first data); ADC_RESP_LSB_TAIL_EN adds the ADC0832 LSB-first tail
module adc_serial_resp
   import adc_resp_pkg::*;
#(
   parameter int DATA_W      = ADC_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              cs_n,
   input  logic              sclk,
   output logic              dout,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_abort
);
   localparam int IW = $clog2(DATA_W);
   adc_resp_state_t   state;
   logic [DATA_W-1:0] shreg;
   logic [IW-1:0]     idx;
   logic              cs_rise, cs_fall, sclk_fall, sclk_rise_unused;
   logic              data_phase;
   sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (cs_n),
      .rise    (cs_rise),
      .fall    (cs_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (sclk),
      .rise    (sclk_rise_unused),
      .fall    (sclk_fall)
   );
`ifdef ADC_RESP_LSB_TAIL_EN
   assign data_phase = (state == DATA) || (state == TAIL);
`else
   assign data_phase = (state == DATA);
`endif
   // frame sequencer: cs_n rise outranks any sclk fall seen in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         shreg       <= '0;
         idx         <= IW'(DATA_W-1);
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         if (cs_rise && state != IDLE && state != DONE) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_abort <= 1'b1;
         end else begin
            case (state)
               IDLE: if (cs_fall) begin
                  shreg <= sample_in;
                  idx   <= IW'(DATA_W-1);
                  state <= MUX;
                  busy  <= 1'b1;
               end
               MUX:   if (sclk_fall) state <= NULLB;
               NULLB: if (sclk_fall) state <= DATA;
               DATA: if (sclk_fall) begin
                  if (idx == '0) begin
`ifdef ADC_RESP_LSB_TAIL_EN
                     state <= TAIL;
                     idx   <= IW'(1);
`else
                     state      <= DONE;
                     frame_done <= 1'b1;
`endif
                  end else begin
                     idx <= idx - 1'b1;
                  end
               end
`ifdef ADC_RESP_LSB_TAIL_EN
               TAIL: if (sclk_fall) begin
                  if (idx == IW'(DATA_W-1)) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
`endif
               DONE: if (cs_rise) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
   // dout follows the state one cycle later, so it settles SYNC_STAGES+2 clocks after the pin edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dout <= ADC_IDLE_LEVEL;
      else          dout <= (state == NULLB) ? ADC_NULL_LEVEL : data_phase ? shreg[idx] : ADC_IDLE_LEVEL;
   end
endmodule

// File: tb/tb_adc_serial_resp.sv
// tb_adc_serial_resp: table-driven and random frames against a bit-sequence model of the serial ADC protocol
module tb_adc_serial_resp;
   localparam int W = 8;
`ifdef ADC_RESP_LSB_TAIL_EN
   localparam int FULL = 2*W + 1;
`else
   localparam int FULL = W + 2;
`endif
   typedef struct {
      logic [W-1:0] s;
      int           nf;
      int           exp_done;
      int           exp_abort;
   } vec_t;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         cs_n = 1'b1;
   logic         sclk = 1'b1;
   logic [W-1:0] sample_in = '0;
   logic         dout, busy, frame_done, frame_abort;
   int           n_chk = 0;
   int           n_pass = 0;
   int           done_cnt = 0;
   int           abort_cnt = 0;
   vec_t         tbl[12];

   always #5 clk = ~clk;

   adc_serial_resp #(.DATA_W(W), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_in   (sample_in),
      .cs_n        (cs_n),
      .sclk        (sclk),
      .dout        (dout),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_abort (frame_abort)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (frame_abort) abort_cnt++;
      if (frame_done || frame_abort) chk("pulse_exclusive", int'(frame_done & frame_abort), 0);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // bit the initiator sees on the sclk rise following fall number k+1
   function automatic int exp_bit(input logic [W-1:0] s, input int k);
      if (k == 0) return 0;
      if (k <= W) return int'(s[W-k]);
`ifdef ADC_RESP_LSB_TAIL_EN
      if (k < 2*W) return int'(s[k-W]);
`endif
      return 1;
   endfunction

   task automatic start_frame(input logic [W-1:0] s);
      sample_in = s;
      wait_clk(2);
      cs_n = 1'b0;
      wait_clk(8);
      sample_in = (s == 8'h3C) ? 8'hC3 : 8'h3C;
   endtask

   task automatic clock_bits(input string tag, input logic [W-1:0] s, input int nf);
      for (int k = 0; k < nf; k++) begin
         sclk = 1'b0;
         wait_clk(8);
         sclk = 1'b1;
         wait_clk(1);
         chk($sformatf("%s_bit%0d", tag, k), int'(dout), exp_bit(s, k));
         wait_clk(7);
      end
   endtask

   task automatic run_frame(input string tag, input logic [W-1:0] s, input int nf, input int ed, input int ea);
      int d0, a0;
      start_frame(s);
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_mux_dout"}, int'(dout), 1);
      d0 = done_cnt;
      a0 = abort_cnt;
      clock_bits(tag, s, nf);
      cs_n = 1'b1;
      wait_clk(8);
      chk({tag, "_done"}, done_cnt - d0, ed);
      chk({tag, "_abort"}, abort_cnt - a0, ea);
      chk({tag, "_idle_busy"}, int'(busy), 0);
      chk({tag, "_idle_dout"}, int'(dout), 1);
   endtask

   initial begin
      int d0, a0;
      tbl[0] = '{8'hA5, FULL, 1, 0};
      tbl[1] = '{8'h81, FULL, 1, 0};
      tbl[2] = '{8'hA5, 5, 0, 1};
      tbl[3] = '{8'hFF, FULL, 1, 0};
      tbl[4] = '{8'h00, 0, 0, 1};
      tbl[5] = '{8'h5A, FULL + 2, 1, 0};
      tbl[6] = '{8'hC3, 1, 0, 1};
      tbl[7] = '{8'h3C, FULL, 1, 0};
      for (int i = 8; i < 12; i++) begin
         tbl[i].s = W'($urandom);
         tbl[i].nf = int'($urandom_range(0, FULL + 2));
         tbl[i].exp_done = (tbl[i].nf >= FULL) ? 1 : 0;
         tbl[i].exp_abort = (tbl[i].nf >= FULL) ? 0 : 1;
      end
      wait_clk(3);
      chk("rst_dout", int'(dout), 1);
      chk("rst_busy", int'(busy), 0);
      reset_n = 1'b1;
      wait_clk(5);
      chk("post_rst_dout", int'(dout), 1);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_pulses", done_cnt + abort_cnt, 0);
      for (int i = 0; i < 12; i++) run_frame($sformatf("v%0d", i), tbl[i].s, tbl[i].nf, tbl[i].exp_done, tbl[i].exp_abort);
      start_frame(8'h96);
      d0 = done_cnt;
      a0 = abort_cnt;
      clock_bits("simul", 8'h96, 4);
      sclk = 1'b0;
      cs_n = 1'b1;
      wait_clk(8);
      chk("simul_abort", abort_cnt - a0, 1);
      chk("simul_done", done_cnt - d0, 0);
      chk("simul_busy", int'(busy), 0);
      chk("simul_dout", int'(dout), 1);
      sclk = 1'b1;
      wait_clk(8);
      run_frame("after_simul", 8'hFF, FULL, 1, 0);
      start_frame(8'hA5);
      d0 = done_cnt;
      a0 = abort_cnt;
      clock_bits("midrst", 8'hA5, FULL - 3);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_dout", int'(dout), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done_q", int'(frame_done), 0);
      chk("midrst_abort_q", int'(frame_abort), 0);
      cs_n = 1'b1;
      sclk = 1'b1;
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(10);
      chk("midrst_no_abort", abort_cnt - a0, 0);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_idle_busy", int'(busy), 0);
      run_frame("after_rst", 8'hA5, FULL, 1, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
